// File: rtl/zig_zag_pkg.sv
// Shared constants, types and the source ROM function for the 8x8 zig-zag scanner.
// Holds:
//   N, DATA_W, ADDR_W, ROW_W  matrix dimension and derived widths
//   dir_t                     diagonal walk direction (UP = row decreasing)
//   state_t                   scanner FSM state
//   src_val(row, col)         constant source matrix, row*N + col truncated to DATA_W
package zig_zag_pkg;

    localparam int unsigned N      = 8;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned ROW_W  = $clog2(N);

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_t;

    typedef enum logic {
        RUN  = 1'b0,
        DONE = 1'b1
    } state_t;

    // Source matrix element at (row, col).
    function automatic logic [DATA_W-1:0] src_val(input logic [ROW_W-1:0] row,
                                                  input logic [ROW_W-1:0] col);
        return DATA_W'((32'(row) * N) + 32'(col));
    endfunction

endpackage

// File: rtl/zig_zag_addr_gen.sv
// Zig-zag coordinate stepper and scan index counter.
// Ports:
//   clk    in   1       rising-edge clock
//   reset  in   1       synchronous, active-high; returns to idx=0, (0,0), UP
//   en     in   1       advance one scan position on this edge
//   row    out  ROW_W   current source row
//   col    out  ROW_W   current source column
//   idx    out  ADDR_W  current scan index (output RAM address)
//   last   out  1       idx is the final scan position (N*N-1)
module zig_zag_addr_gen
    import zig_zag_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    output logic [ROW_W-1:0]  row,
    output logic [ROW_W-1:0]  col,
    output logic [ADDR_W-1:0] idx,
    output logic              last
);

    localparam logic [ROW_W-1:0]  EDGE     = ROW_W'(N - 1);
    localparam logic [ADDR_W-1:0] PRE_LAST = ADDR_W'(N * N - 2);

    dir_t dir;

    // Edge checks on the far row/column come first so the two off-diagonal
    // corners turn onto the next diagonal instead of stepping out of range.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx  <= '0;
            row  <= '0;
            col  <= '0;
            dir  <= UP;
            last <= 1'b0;
        end else if (en) begin
            idx  <= idx + ADDR_W'(1);
            last <= (idx == PRE_LAST);
            unique case (dir)
                UP: begin
                    if (col == EDGE) begin
                        row <= row + ROW_W'(1);
                        dir <= DOWN;
                    end else if (row == '0) begin
                        col <= col + ROW_W'(1);
                        dir <= DOWN;
                    end else begin
                        row <= row - ROW_W'(1);
                        col <= col + ROW_W'(1);
                    end
                end
                DOWN: begin
                    if (row == EDGE) begin
                        col <= col + ROW_W'(1);
                        dir <= UP;
                    end else if (col == '0) begin
                        row <= row + ROW_W'(1);
                        dir <= UP;
                    end else begin
                        row <= row + ROW_W'(1);
                        col <= col - ROW_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/zig_zag_traversal.sv
// Self-starting 8x8 zig-zag scanner: after reset, writes element k of the JPEG
// zig-zag scan of the constant source matrix to output RAM address k, then
// raises a sticky done flag.
// Ports:
//   clk            in   1       rising-edge clock
//   reset          in   1       synchronous, active-high; restarts the scan
//   done           out  1       all N*N entries written; sticky until reset
//   ram_read_addr  in   ADDR_W  output-RAM read address
//   ram_read_data  out  DATA_W  output-RAM data at ram_read_addr
// Configuration:
//   ZZ_REG_READ_EN  when defined, ram_read_data is registered (one edge of
//                   latency, resets to 0); otherwise the read is combinational.
module zig_zag_traversal
    import zig_zag_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    output logic              done,
    input  logic [ADDR_W-1:0] ram_read_addr,
    output logic [DATA_W-1:0] ram_read_data
);

    state_t            state;
    logic [ROW_W-1:0]  row;
    logic [ROW_W-1:0]  col;
    logic [ADDR_W-1:0] idx;
    logic              last;
    logic              run;

    logic [DATA_W-1:0] ram [N*N];

    assign run = (state == RUN);

    zig_zag_addr_gen u_addr_gen (
        .clk   (clk),
        .reset (reset),
        .en    (run),
        .row   (row),
        .col   (col),
        .idx   (idx),
        .last  (last)
    );

    // Scanner FSM: RUN until the final entry is written, then park in DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            done  <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (last) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    done <= 1'b1;
                end
            endcase
        end
    end

    // Output RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (!reset && run) begin
            ram[idx] <= src_val(row, col);
        end
    end

`ifdef ZZ_REG_READ_EN
    // Registered read port.
    always_ff @(posedge clk) begin
        if (reset) begin
            ram_read_data <= '0;
        end else begin
            ram_read_data <= ram[ram_read_addr];
        end
    end
`else
    // Combinational read port.
    assign ram_read_data = ram[ram_read_addr];
`endif

endmodule

// File: tb/tb_zig_zag_traversal.sv
// Directed self-checking bench for zig_zag_traversal: done latency and stickiness,
// output RAM contents against an independently built zig-zag sequence, and
// reset during and after a scan.
module tb_zig_zag_traversal;

    logic       clk;
    logic       reset;
    logic       done;
    logic [5:0] ram_read_addr;
    logic [7:0] ram_read_data;

    int pass_cnt  = 0;
    int check_cnt = 0;
    int exp_seq [64];

    zig_zag_traversal dut (
        .clk           (clk),
        .reset         (reset),
        .done          (done),
        .ram_read_addr (ram_read_addr),
        .ram_read_data (ram_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        check_cnt++;
        if (got == exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Zig-zag order by anti-diagonals: even sums climb (row falling), odd sums descend.
    task automatic build_model();
        int k = 0;
        for (int s = 0; s <= 14; s++) begin
            int r_hi = (s < 8) ? s : 7;
            int r_lo = (s > 7) ? s - 7 : 0;
            if (s % 2 == 0) begin
                for (int r = r_hi; r >= r_lo; r--) begin
                    exp_seq[k] = r * 8 + (s - r);
                    k++;
                end
            end else begin
                for (int r = r_lo; r <= r_hi; r++) begin
                    exp_seq[k] = r * 8 + (s - r);
                    k++;
                end
            end
        end
    endtask

    // Apply an address at the falling edge and return the read data.
    task automatic read_ram(input int addr, output int data);
        @(negedge clk);
        ram_read_addr = 6'(addr);
`ifdef ZZ_REG_READ_EN
        @(posedge clk);
`endif
        #1;
        data = int'(ram_read_data);
    endtask

    // Count edges from reset release until done rises, bounded.
    task automatic wait_done(output int edges);
        edges = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            @(negedge clk);
            edges++;
            if (done) break;
        end
    endtask

    task automatic check_full_ram(input string tag);
        int   data;
        logic [63:0] seen;
        int   bad;
        seen = '0;
        bad  = 0;
        for (int a = 0; a < 64; a++) begin
            read_ram(a, data);
            if (data != exp_seq[a]) bad++;
            if (data >= 0 && data < 64) seen[data] = 1'b1;
        end
        check_val({tag, "_entries_bad"}, bad, 0);
        check_val({tag, "_coverage"}, int'(seen == '1), 1);
    endtask

    initial begin
        int edges;
        int data;
        int low_cnt;
        int exp_head [8];
        int exp_tail [4];

        exp_head = '{0, 1, 8, 16, 9, 2, 3, 10};
        exp_tail = '{47, 55, 62, 63};
        build_model();

        reset = 1'b1;
        ram_read_addr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("reset_done", int'(done), 0);

        // Initial scan: done low for 63 edges, high at edge 64.
        reset = 1'b0;
        low_cnt = 0;
        for (int e = 1; e <= 63; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) low_cnt++;
        end
        check_val("done_early_edges", low_cnt, 0);
        @(posedge clk);
        @(negedge clk);
        check_val("done_at_64", int'(done), 1);

        low_cnt = 0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (!done) low_cnt++;
        end
        check_val("done_sticky_low_cycles", low_cnt, 0);

        for (int a = 0; a < 8; a++) begin
            read_ram(a, data);
            check_val($sformatf("head_addr%0d", a), data, exp_head[a]);
        end
        for (int a = 60; a < 64; a++) begin
            read_ram(a, data);
            check_val($sformatf("tail_addr%0d", a), data, exp_tail[a-60]);
        end
        check_full_ram("run1");

`ifdef ZZ_REG_READ_EN
        // Registered read: new address only visible after the next edge.
        read_ram(0, data);
        @(negedge clk);
        ram_read_addr = 6'd3;
        #1;
        check_val("regread_same_cycle", int'(ram_read_data), 0);
        @(posedge clk);
        #1;
        check_val("regread_next_edge", int'(ram_read_data), 16);
`endif

        // Reset pulsed at edge 30 of a fresh run.
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (30) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_val("midrun_reset_done", int'(done), 0);
        reset = 1'b0;
        wait_done(edges);
        check_val("midrun_latency", edges, 64);
        check_full_ram("run2");

        // Reset while done is high.
        @(negedge clk);
        check_val("pre_reset_done", int'(done), 1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_val("done_reset_clears", int'(done), 0);
        reset = 1'b0;
        wait_done(edges);
        check_val("rerun_latency", edges, 64);
        check_full_ram("run3");

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks so far", pass_cnt, check_cnt);
        $fatal(1, "watchdog");
    end

endmodule
